// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_pkg
//  Description : Shared constants for the SPI command RAM: opcode field width,
//                opcode encodings and a small width helper.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package spi_ram_pkg;

   localparam int OP_W = 2;

   localparam logic [OP_W-1:0] OP_SET_WADDR = 2'b00;
   localparam logic [OP_W-1:0] OP_WRITE     = 2'b01;
   localparam logic [OP_W-1:0] OP_SET_RADDR = 2'b10;
   localparam logic [OP_W-1:0] OP_READ      = 2'b11;

   // Payload must be wide enough for either an address or a data word.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_sp_array.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_sp_array
//  Description : Single-port synchronous RAM, MEM_DEPTH x DATA_W, registered
//                read data, no reset on the array or the read register.
//  Ports       : clk   - clock, rising edge
//                we    - write enable
//                re    - read enable (loads rdata from mem[addr])
//                addr  - word address, must be < MEM_DEPTH
//                wdata - write data
//                rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_sp_array #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

   // No reset here so the array and its output register map onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_ctrl
//  Description : Command decoder in front of a single-port RAM. Commands come
//                from the SPI slave receive word, read data goes back to its
//                transmit path through a valid/ready handshake.
//  Ports       : clk, rst_n       - clock / async active-low reset
//                din              - {opcode[1:0], payload[PAY_W-1:0]}
//                rx_valid/rx_ready- command handshake
//                dout             - read data (0 while tx_valid is low)
//                tx_valid/tx_ready- read-data handshake
//                addr_err         - one-cycle pulse on out-of-range SET_*ADDR
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int  MEM_DEPTH = 256,
   parameter int  ADDR_W    = 8,
   parameter int  DATA_W    = 8,
   parameter int  AUTO_INC  = 1,
   localparam int PAY_W     = max_int(ADDR_W, DATA_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PAY_W+OP_W-1:0] din,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [DATA_W-1:0]     dout,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  addr_err
);

   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [ADDR_W:0]   C_DEPTH     = (ADDR_W + 1)'(MEM_DEPTH);

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic              tx_valid_q, tx_valid_d;
   logic              addr_err_q, addr_err_d;

   logic [OP_W-1:0]   w_op;
   logic [ADDR_W-1:0] w_pay_addr;
   logic [DATA_W-1:0] w_pay_data;
   logic              w_out_of_range;
   logic              w_accept;
   logic              w_ram_we;
   logic              w_ram_re;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_rdata;
   logic              unused_din;

   // Wrapping increment: the last valid word goes back to 0 for any depth.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == C_LAST_ADDR) ? '0 : p + ADDR_W'(1);
   endfunction

   assign w_op           = din[PAY_W+OP_W-1:PAY_W];
   assign w_pay_addr     = din[ADDR_W-1:0];
   assign w_pay_data     = din[DATA_W-1:0];
   assign w_out_of_range = ({1'b0, w_pay_addr} >= C_DEPTH);
   // Payload bits above ADDR_W/DATA_W carry no meaning.
   assign unused_din     = ^din;

   // A pending, unconsumed word blocks every command, not only READs.
   assign rx_ready = !tx_valid_q || tx_ready;
   assign w_accept = rx_valid && rx_ready;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      tx_valid_d = tx_valid_q;
      addr_err_d = 1'b0;
      w_ram_we   = 1'b0;
      w_ram_re   = 1'b0;
      w_ram_addr = rptr_q;

      if (tx_valid_q && tx_ready) begin
         tx_valid_d = 1'b0;
      end

      if (w_accept) begin
         case (w_op)
            OP_SET_WADDR: begin
               if (w_out_of_range) begin
                  addr_err_d = 1'b1;
               end else begin
                  wptr_d = w_pay_addr;
               end
            end
            OP_WRITE: begin
               w_ram_we   = 1'b1;
               w_ram_addr = wptr_q;
               if (AUTO_INC != 0) begin
                  wptr_d = ptr_inc(wptr_q);
               end
            end
            OP_SET_RADDR: begin
               if (w_out_of_range) begin
                  addr_err_d = 1'b1;
               end else begin
                  rptr_d = w_pay_addr;
               end
            end
            default: begin  // OP_READ
               w_ram_re   = 1'b1;
               tx_valid_d = 1'b1;  // overrides the clear for back-to-back reads
               if (AUTO_INC != 0) begin
                  rptr_d = ptr_inc(rptr_q);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         tx_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         tx_valid_q <= tx_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   spi_ram_sp_array #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (w_ram_we),
      .re    (w_ram_re),
      .addr  (w_ram_addr),
      .wdata (w_pay_data),
      .rdata (w_ram_rdata)
   );

   // The RAM read register has no reset; gating with tx_valid gives a clean
   // zero on dout out of reset and the moment reset is asserted. The RAM
   // register only reloads on an accepted READ, so dout holds under stall.
   assign dout     = tx_valid_q ? w_ram_rdata : '0;
   assign tx_valid = tx_valid_q;
   assign addr_err = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ram_ctrl
//  Description : Self-checking bench for spi_ram_ctrl. Three instances:
//                0 = 256 deep auto-inc, 1 = 200 deep auto-inc,
//                2 = 256 deep without auto-inc. Expected read words are queued
//                when a READ is issued and compared when the word is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;

   localparam logic [1:0] C_SWA = 2'b00;
   localparam logic [1:0] C_WR  = 2'b01;
   localparam logic [1:0] C_SRA = 2'b10;
   localparam logic [1:0] C_RD  = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] din [3];
   logic [2:0] rx_valid;
   logic [2:0] rx_ready;
   logic [7:0] dout [3];
   logic [2:0] tx_valid;
   logic [2:0] tx_ready;
   logic [2:0] addr_err;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   int         err_cnt [3];
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .din(din[0]), .rx_valid(rx_valid[0]),
      .rx_ready(rx_ready[0]), .dout(dout[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .addr_err(addr_err[0]));

   spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .din(din[1]), .rx_valid(rx_valid[1]),
      .rx_ready(rx_ready[1]), .dout(dout[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .addr_err(addr_err[1]));

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_W(8), .DATA_W(8), .AUTO_INC(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .din(din[2]), .rx_valid(rx_valid[2]),
      .rx_ready(rx_ready[2]), .dout(dout[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .addr_err(addr_err[2]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic push_exp(input int k, input logic [7:0] v);
      case (k)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic pop_chk(input int k);
      logic [7:0] e;
      int         sz;
      sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         chk($sformatf("unexpected_tx%0d", k), 32'(dout[k]), 32'hDEAD);
      end else begin
         case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         chk($sformatf("rd_data%0d", k), 32'(dout[k]), 32'(e));
      end
   endtask

   // Scoreboard side: sampled on the falling edge, inputs move just after rise.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (tx_valid[k] && tx_ready[k]) pop_chk(k);
            if (addr_err[k]) err_cnt[k]++;
         end
      end
   end

   // Present one command; returns 1 ns after the edge that accepted it.
   task automatic cmd(input int k, input logic [1:0] op, input logic [7:0] pay);
      int n;
      n = 0;
      din[k]      = {op, pay};
      rx_valid[k] = 1'b1;
      @(negedge clk);
      while (!rx_ready[k] && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("cmd_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      rx_valid[k] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      rx_valid = '0;
      tx_ready = '1;
      for (int k = 0; k < 3; k++) begin
         din[k]     = '0;
         err_cnt[k] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tx_valid", 32'(tx_valid[0]), 32'd0);
      chk("rst_dout",     32'(dout[0]),     32'd0);
      chk("rst_addr_err", 32'(addr_err[0]), 32'd0);
      chk("rst_rx_ready", 32'(rx_ready[0]), 32'd1);
      @(posedge clk);
      #1;

      // Basic write / read-back with one-cycle latency.
      cmd(0, C_SWA, 8'h10);
      cmd(0, C_WR,  8'hA5);
      cmd(0, C_SRA, 8'h10);
      push_exp(0, 8'hA5);
      cmd(0, C_RD,  8'h00);
      chk("lat_tx_valid", 32'(tx_valid[0]), 32'd1);
      chk("lat_dout",     32'(dout[0]),     32'hA5);
      @(posedge clk);
      #1;
      chk("lat_single_cycle", 32'(tx_valid[0]), 32'd0);

      // Burst across the 0xFF -> 0x00 wrap.
      cmd(0, C_SWA, 8'hFE);
      cmd(0, C_WR,  8'h11);
      cmd(0, C_WR,  8'h22);
      cmd(0, C_WR,  8'h33);
      cmd(0, C_SRA, 8'hFE);
      push_exp(0, 8'h11);
      push_exp(0, 8'h22);
      push_exp(0, 8'h33);
      cmd(0, C_RD, 8'h00);
      chk("burst_tv0", 32'(tx_valid[0]), 32'd1);
      cmd(0, C_RD, 8'h00);
      chk("burst_tv1", 32'(tx_valid[0]), 32'd1);
      cmd(0, C_RD, 8'h00);
      chk("burst_tv2", 32'(tx_valid[0]), 32'd1);
      @(posedge clk);
      #1;

      // Backpressure: word held, commands stalled, stalled SET_RADDR dropped.
      cmd(0, C_SRA, 8'hFE);
      tx_ready[0] = 1'b0;
      push_exp(0, 8'h11);
      cmd(0, C_RD, 8'h00);
      din[0]      = {C_SRA, 8'h10};
      rx_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_tx_valid", 32'(tx_valid[0]), 32'd1);
         chk("bp_dout",     32'(dout[0]),     32'h11);
         chk("bp_rx_ready", 32'(rx_ready[0]), 32'd0);
      end
      @(posedge clk);
      #1;
      rx_valid[0] = 1'b0;
      tx_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_rx_ready", 32'(rx_ready[0]), 32'd1);
      @(posedge clk);
      #1;
      push_exp(0, 8'h22);  // pointer continued from 0xFF, not 0x10
      cmd(0, C_RD, 8'h00);

      // Non-power-of-two depth: range check and wrap at 199.
      cmd(1, C_SWA, 8'h05);
      cmd(1, C_SWA, 8'hC8);
      chk("err_pulse", 32'(addr_err[1]), 32'd1);
      @(posedge clk);
      #1;
      chk("err_one_cycle", 32'(addr_err[1]), 32'd0);
      cmd(1, C_WR,  8'h5A);
      cmd(1, C_SRA, 8'h05);
      push_exp(1, 8'h5A);
      cmd(1, C_RD,  8'h00);
      cmd(1, C_SWA, 8'hC7);
      chk("err_last_in_range", 32'(addr_err[1]), 32'd0);
      cmd(1, C_WR,  8'h99);
      cmd(1, C_WR,  8'h98);
      cmd(1, C_SRA, 8'hC7);
      push_exp(1, 8'h99);
      push_exp(1, 8'h98);
      cmd(1, C_RD,  8'h00);
      cmd(1, C_RD,  8'h00);

      // No auto-increment: repeated reads return the same word.
      cmd(2, C_SWA, 8'h04);
      cmd(2, C_WR,  8'hEE);
      cmd(2, C_SWA, 8'h03);
      cmd(2, C_WR,  8'h3C);
      cmd(2, C_WR,  8'h4D);
      cmd(2, C_SRA, 8'h03);
      push_exp(2, 8'h4D);
      push_exp(2, 8'h4D);
      cmd(2, C_RD,  8'h00);
      cmd(2, C_RD,  8'h00);
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset mid-cycle with a word pending.
      tx_ready[0] = 1'b0;
      cmd(0, C_RD, 8'h00);
      chk("pre_rst_tx_valid", 32'(tx_valid[0]), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tx_valid", 32'(tx_valid[0]), 32'd0);
      chk("async_rst_dout",     32'(dout[0]),     32'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      tx_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      cmd(0, C_WR, 8'h77);
      push_exp(0, 8'h77);
      cmd(0, C_RD, 8'h00);
      repeat (4) @(posedge clk);
      #1;

      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      chk("err_cnt0", 32'(err_cnt[0]), 32'd0);
      chk("err_cnt1", 32'(err_cnt[1]), 32'd1);
      chk("err_cnt2", 32'(err_cnt[2]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
